// File: rtl/fetch_unit.sv
// fetch_unit: MIPS IF stage with PC, sync-read imem interface, 1-entry skid; optional perf counters via FETCH_PERF_EN
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_pc4,
  input  logic [15:0]        br_imm16,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        if_inst,
  output logic [31:0]        if_pc4,
  output logic               if_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);
  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc4_q, req_pc4_d, skid_inst_q, skid_inst_d, skid_pc4_q, skid_pc4_d;
  logic [31:0] inst_q, inst_d, pc4_q, pc4_d, target, fa, fa4;
  logic        req_v_q, req_v_d, skid_v_q, skid_v_d, valid_q, valid_d, issue, capture;
  assign target    = br_pc4 + {{14{br_imm16[15]}}, br_imm16, 2'b00};
  assign fa        = br_taken ? target : pc_q;
  assign fa4       = fa + 32'd4;
  assign issue     = br_taken | ~stall;
  assign capture   = stall & ~br_taken & req_v_q & (state_q == RUN);
  assign imem_addr = fa[IMEM_AW+1:2];
  assign if_inst   = inst_q;
  assign if_pc4    = pc4_q;
  assign if_valid  = valid_q;
  // next-state: issue, skid capture/drain, output selection; redirect beats stall
  always_comb begin
    pc_d        = issue ? fa4 : pc_q;
    req_v_d     = issue;
    req_pc4_d   = issue ? fa4 : req_pc4_q;
    skid_v_d    = capture | (stall & ~br_taken & skid_v_q);
    skid_inst_d = capture ? imem_rdata : skid_inst_q;
    skid_pc4_d  = capture ? req_pc4_q : skid_pc4_q;
    valid_d     = br_taken ? 1'b0 : stall ? valid_q : (skid_v_q | req_v_q);
    inst_d      = br_taken ? 32'h0 : stall ? inst_q : skid_v_q ? skid_inst_q : req_v_q ? imem_rdata : 32'h0;
    pc4_d       = (br_taken | stall) ? pc4_q : skid_v_q ? skid_pc4_q : req_v_q ? req_pc4_q : pc4_q;
    state_d     = br_taken ? RUN :
                  (state_q == FILL) ? (issue ? RUN : FILL) :
                  (state_q == RUN)  ? (capture ? HOLD : RUN) :
                  (stall ? HOLD : RUN);
  end
  // state registers; reset discards skid and in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      pc_q        <= RESET_PC;
      req_v_q     <= 1'b0;
      req_pc4_q   <= 32'h0;
      skid_v_q    <= 1'b0;
      skid_inst_q <= 32'h0;
      skid_pc4_q  <= 32'h0;
      inst_q      <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_v_q     <= req_v_d;
      req_pc4_q   <= req_pc4_d;
      skid_v_q    <= skid_v_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubbles_q;
  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
  // count edges that load a valid word and unstalled edges that load a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= 32'h0;
      bubbles_q <= 32'h0;
    end else begin
      fetched_q <= fetched_q + {31'h0, valid_d};
      bubbles_q <= bubbles_q + {31'h0, ~valid_d & ~stall};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based fetch-stream model and literal spot checks
module tb_fetch_unit;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, br_taken = 1'b0;
  logic [31:0] br_pc4 = 32'h0;
  logic [15:0] br_imm16 = 16'h0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, if_inst, if_pc4;
  logic        if_valid;
  logic [31:0] mem [1024];
  int          checks = 0, errors = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
  logic [31:0] m_fetched = 0, m_bubbles = 0;
`endif
  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_pc4(br_pc4),
    .br_imm16(br_imm16), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );
  always #5 clk = ~clk;
  initial for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: pc plus a queue of issued-but-undelivered PC+4 values
  logic [31:0] m_pc = 0, m_inst = 0, m_pc4 = 0, t, p, a;
  logic        m_v = 0;
  logic [31:0] q[$];
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; q.delete(); m_inst = 0; m_pc4 = 0; m_v = 0;
`ifdef FETCH_PERF_EN
      m_fetched = 0; m_bubbles = 0;
`endif
    end else begin
      if (br_taken) begin
        t = br_pc4 + ({{16{br_imm16[15]}}, br_imm16} << 2);
        m_v = 0; m_inst = 0; q.delete();
        q.push_back(t + 4); m_pc = t + 4;
      end else if (!stall) begin
        if (q.size() > 0) begin
          p = q.pop_front(); a = p - 32'd4;
          m_v = 1; m_pc4 = p; m_inst = mem[a[11:2]];
        end else begin
          m_v = 0; m_inst = 0;
        end
        q.push_back(m_pc + 4); m_pc = m_pc + 4;
      end
`ifdef FETCH_PERF_EN
      if (m_v) m_fetched++;
      if (!m_v && !stall) m_bubbles++;
`endif
    end
    #1;
    chk("model_valid", {31'h0, if_valid}, {31'h0, m_v});
    chk("model_inst", if_inst, m_inst);
    chk("model_pc4", if_pc4, m_pc4);
`ifdef FETCH_PERF_EN
    chk("model_perf_fetched", perf_fetched, m_fetched);
    chk("model_perf_bubbles", perf_bubbles, m_bubbles);
`endif
  end

  task automatic step(input logic rs, input logic st, input logic br, input logic [31:0] bp, input logic [15:0] bi);
    @(negedge clk);
    reset = rs; stall = st; br_taken = br; br_pc4 = bp; br_imm16 = bi;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic v, input logic [31:0] inst, input logic [31:0] pc4);
    chk({name, "_valid"}, {31'h0, if_valid}, {31'h0, v});
    chk({name, "_inst"}, if_inst, inst);
    chk({name, "_pc4"}, if_pc4, pc4);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    lit("reset", 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("edge1_valid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    lit("edge2", 1, 32'h1000_0000, 32'h4);
    step(0, 0, 0, 0, 0);
    lit("edge3", 1, 32'h1000_0001, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      lit("stall_hold", 1, 32'h1000_0001, 32'h8);
    end
    step(0, 0, 0, 0, 0);
    lit("skid_drain", 1, 32'h1000_0002, 32'hC);
    step(0, 0, 0, 0, 0);
    lit("after_drain", 1, 32'h1000_0003, 32'h10);
    step(0, 0, 1, 32'h20, 16'hFFFC);
    lit("br_bubble", 0, 32'h0, 32'h10);
    step(0, 0, 0, 0, 0);
    lit("br_target", 1, 32'h1000_0004, 32'h14);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h100, 16'h0010);
    chk("hold_br_valid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    lit("hold_br_target", 1, 32'h1000_0050, 32'h144);
    step(0, 0, 0, 0, 0);
    lit("hold_br_next", 1, 32'h1000_0051, 32'h148);
    step(0, 0, 1, 32'h0, 16'hFFFF);
    step(0, 0, 0, 0, 0);
    lit("wrap_top", 1, 32'h1000_03FF, 32'h0);
    step(0, 0, 0, 0, 0);
    lit("wrap_zero", 1, 32'h1000_0000, 32'h4);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h40, 16'h0004);
    lit("reset_hold", 0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("reset_perf_fetched", perf_fetched, 32'h0);
    chk("reset_perf_bubbles", perf_bubbles, 32'h0);
`endif
    step(0, 0, 0, 0, 0);
    chk("re_edge1_valid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    lit("re_edge2", 1, 32'h1000_0000, 32'h4);
    for (int i = 0; i < 6; i++) step(0, (i % 3) == 1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
